// File: rtl/fog_frame_tx.sv
// FOG frame transmitter: snapshots step/err on a trigger and streams a
// 12-byte framed packet (header, payload, seq, checksum) to the UART.
module fog_frame_tx #(
  parameter logic [7:0] HDR0 = 8'hAB,
  parameter logic [7:0] HDR1 = 8'hBA
) (
  input  logic        CLOCK_CPU,
  input  logic        RST_SYNC,
  input  logic        i_sync_in,
  input  logic        i_sel_ext,
  input  logic [31:0] i_trig_period,
  input  logic [31:0] i_step,
  input  logic [31:0] i_err,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_busy,
  output logic [7:0]  o_seq,
  output logic [7:0]  o_drop_cnt
);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_sync;
  logic [31:0] r_tmr;
  logic [31:0] w_tmr_nxt;
  logic [3:0]  r_idx;
  logic [3:0]  w_idx_nxt;
  logic [3:0]  w_idx_inc;
  logic [31:0] r_step;
  logic [31:0] r_err;
  logic [7:0]  r_seq;
  logic [7:0]  r_drop;
  logic [7:0]  r_data;
  logic [7:0]  w_data_nxt;
  logic [7:0]  w_byte;
  logic [7:0]  w_csum;
  logic        w_ext_trig;
  logic        w_tmr_en;
  logic        w_tmr_hit;
  logic        w_trig;
  logic        w_load;
  logic        w_done;

  assign w_ext_trig = i_sel_ext & r_sync[1] & ~r_sync[2];
  assign w_tmr_en   = !i_sel_ext && (i_trig_period != 32'd0);
  // >= so a freshly lowered period fires at once instead of wrapping 2^32
  assign w_tmr_hit  = w_tmr_en && (r_tmr >= i_trig_period - 32'd1);
  assign w_trig     = w_ext_trig | w_tmr_hit;
  assign w_tmr_nxt  = (!w_tmr_en || w_tmr_hit) ? 32'd0 : r_tmr + 32'd1;

  assign w_csum = r_step[31:24] + r_step[23:16] + r_step[15:8]
                + r_step[7:0]   + r_err[31:24]  + r_err[23:16]
                + r_err[15:8]   + r_err[7:0]    + r_seq;

  assign w_idx_inc = r_idx + 4'd1;

  always_comb begin
    w_byte = w_csum;
    case (w_idx_inc)
      4'd1:    w_byte = HDR1;
      4'd2:    w_byte = r_step[31:24];
      4'd3:    w_byte = r_step[23:16];
      4'd4:    w_byte = r_step[15:8];
      4'd5:    w_byte = r_step[7:0];
      4'd6:    w_byte = r_err[31:24];
      4'd7:    w_byte = r_err[23:16];
      4'd8:    w_byte = r_err[15:8];
      4'd9:    w_byte = r_err[7:0];
      4'd10:   w_byte = r_seq;
      default: w_byte = w_csum;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_data_nxt  = r_data;
    w_load      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_trig) begin
          w_state_nxt = S_SEND;
          w_idx_nxt   = 4'd0;
          w_data_nxt  = HDR0;
          w_load      = 1'b1;
        end
      end
      S_SEND: begin
        if (i_tx_ready) begin
          if (r_idx == 4'd11) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = 4'd0;
            w_data_nxt  = 8'h00;
            w_done      = 1'b1;
          end else begin
            w_idx_nxt  = w_idx_inc;
            w_data_nxt = w_byte;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_CPU or posedge RST_SYNC) begin
    if (RST_SYNC) begin
      r_state <= S_IDLE;
      r_sync  <= 3'd0;
      r_tmr   <= 32'd0;
      r_idx   <= 4'd0;
      r_step  <= 32'd0;
      r_err   <= 32'd0;
      r_seq   <= 8'd0;
      r_drop  <= 8'd0;
      r_data  <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_sync  <= {r_sync[1:0], i_sync_in};
      r_tmr   <= w_tmr_nxt;
      r_idx   <= w_idx_nxt;
      r_data  <= w_data_nxt;
      if (w_load) begin
        r_step <= i_step;
        r_err  <= i_err;
      end
      if (w_done)
        r_seq <= r_seq + 8'd1;
      if (w_trig && (r_state == S_SEND) && (r_drop != 8'hFF))
        r_drop <= r_drop + 8'd1;
    end
  end

  assign o_tx_valid = (r_state == S_SEND);
  assign o_busy     = (r_state == S_SEND);
  assign o_tx_data  = r_data;
  assign o_seq      = r_seq;
  assign o_drop_cnt = r_drop;

endmodule
